// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 sequential demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STAT_W = 8;

  // Round-robin successor; the natural 2-bit wrap gives 3 -> 0.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return ch + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single demux output channel.
// A load in the same cycle as a drain keeps the entry valid and replaces the data.
module demux_chan_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next state: drain first, then a load overrides it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Entry state with synchronous reset; data is cleared too so outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_1to4_seq.sv
// Sequential 1-to-4 demultiplexer with valid/ready on the input and on each channel.
// Routing is by {s1,s0} in fixed mode or by a round-robin pointer in auto mode.
// Optional per-channel saturating load counters are enabled with DEMUX_STATS_EN.
module demux_1to4_seq
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RR_START = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s1,
  input  logic                     s0,
  input  logic                     auto_mode,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [SEL_W-1:0]         cur_ch
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] acc_cnt
`endif
);

  logic [SEL_W-1:0]  rr_d, rr_q;
  logic [SEL_W-1:0]  tgt;
  logic              accept;
  logic [NUM_CH-1:0] load;

  // Target channel, input readiness and per-channel load strobes.
  always_comb begin
    tgt      = auto_mode ? rr_q : {s1, s0};
    in_ready = !out_valid[tgt] || out_ready[tgt];
    accept   = in_valid && in_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept && (tgt == SEL_W'(k));
    end
  end

  assign cur_ch = tgt;

  // Pointer only moves on an accepted word in auto mode; it survives mode switches.
  always_comb begin
    rr_d = rr_q;
    if (accept && auto_mode) begin
      rr_d = next_ch(rr_q);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= SEL_W'(RR_START);
    end else begin
      rr_q <= rr_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_reg #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*DATA_W +: DATA_W])
    );

    // A held word must not change until the consumer takes it.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid[k] && !out_ready[k]) |=> $stable(out_data[k*DATA_W +: DATA_W]));
  end

`ifdef DEMUX_STATS_EN
  logic [STAT_W-1:0] cnt_d [NUM_CH];
  logic [STAT_W-1:0] cnt_q [NUM_CH];

  // Saturating per-channel load counters.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (load[k] && (cnt_q[k] != {STAT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + STAT_W'(1);
      end
      acc_cnt[k*STAT_W +: STAT_W] = cnt_q[k];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        cnt_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_1to4_seq.sv
// Self-checking bench for demux_1to4_seq: directed table, random traffic vs. a
// behavioural model, and (with DEMUX_STATS_EN) counter saturation.
module tb_demux_1to4_seq;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RR_START = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        s1, s0, auto_mode;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  cur_ch;
`ifdef DEMUX_STATS_EN
  logic [31:0] acc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model of the channel contents.
  bit          m_ok = 0;
  bit          m_v   [4];
  logic [7:0]  m_d   [4];
  int          m_ptr;
  int          m_cnt [4];

  typedef struct {
    logic       rst;
    logic       auto_m;
    logic [1:0] sel;
    logic [7:0] data;
    logic       valid;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [1:0] exp_ch;
    logic [3:0] exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [21];
  vec_t none;

  demux_1to4_seq #(
    .DATA_W   (DATA_W),
    .RR_START (RR_START)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s1        (s1),
    .s0        (s0),
    .auto_mode (auto_mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_ch    (cur_ch)
`ifdef DEMUX_STATS_EN
    ,
    .acc_cnt   (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic am, input logic [1:0] sel,
                       input logic [7:0] d, input logic v, input logic [3:0] ordy);
    rst = r; auto_mode = am; {s1, s0} = sel; in_data = d; in_valid = v; out_ready = ordy;
  endtask

  // One clock: check outputs mid-cycle against the model (and optionally a table row),
  // then advance the model across the rising edge.
  task automatic step(input bit use_tbl, input vec_t v);
    int          t;
    bit          rdy;
    logic [31:0] ed;
    logic [3:0]  ev;
    bit          nv [4];
    logic [7:0]  nd [4];
    int          np;
    int          nc [4];
    @(negedge clk);
    t   = auto_mode ? m_ptr : int'({s1, s0});
    rdy = !m_v[t] || (out_ready[t] === 1'b1);
    if (m_ok) begin
      for (int k = 0; k < 4; k++) begin
        ev[k] = m_v[k];
        ed[k*8 +: 8] = m_d[k];
      end
      chk("model_in_ready", 64'(in_ready), 64'(rdy));
      chk("model_cur_ch", 64'(cur_ch), 64'(t));
      chk("model_out_valid", 64'(out_valid), 64'(ev));
      chk("model_out_data", 64'(out_data), 64'(ed));
`ifdef DEMUX_STATS_EN
      for (int k = 0; k < 4; k++) begin
        chk("model_acc_cnt", 64'(acc_cnt[k*8 +: 8]), 64'(m_cnt[k]));
      end
`endif
    end
    if (use_tbl) begin
      chk("tbl_in_ready", 64'(in_ready), 64'(v.exp_rdy));
      chk("tbl_cur_ch", 64'(cur_ch), 64'(v.exp_ch));
      chk("tbl_out_valid", 64'(out_valid), 64'(v.exp_v));
      chk("tbl_out_data", 64'(out_data), 64'(v.exp_d));
    end
    np = m_ptr;
    for (int k = 0; k < 4; k++) begin
      nv[k] = m_v[k]; nd[k] = m_d[k]; nc[k] = m_cnt[k];
    end
    if (rst) begin
      np = RR_START;
      for (int k = 0; k < 4; k++) begin
        nv[k] = 0; nd[k] = 8'h00; nc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_v[k] && out_ready[k]) nv[k] = 0;
      end
      if (in_valid && rdy) begin
        nv[t] = 1;
        nd[t] = in_data;
        if (nc[t] < 255) nc[t] = nc[t] + 1;
        if (auto_mode) np = (m_ptr + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
    m_ptr = np;
    for (int k = 0; k < 4; k++) begin
      m_v[k] = nv[k]; m_d[k] = nd[k]; m_cnt[k] = nc[k];
    end
    if (rst) m_ok = 1;
  endtask

  initial begin
    // rst auto sel data valid ordy | rdy ch valid data
    vecs[0]  = '{0, 0, 2'd2, 8'hA5, 1, 4'b0000, 1, 2'd2, 4'b0000, 32'h0000_0000};
    vecs[1]  = '{0, 0, 2'd2, 8'h00, 0, 4'b0000, 0, 2'd2, 4'b0100, 32'h00A5_0000};
    vecs[2]  = '{0, 0, 2'd2, 8'h00, 0, 4'b0100, 1, 2'd2, 4'b0100, 32'h00A5_0000};
    vecs[3]  = '{0, 1, 2'd0, 8'h11, 1, 4'b1111, 1, 2'd0, 4'b0000, 32'h00A5_0000};
    vecs[4]  = '{0, 1, 2'd0, 8'h22, 1, 4'b1111, 1, 2'd1, 4'b0001, 32'h00A5_0011};
    vecs[5]  = '{0, 1, 2'd0, 8'h33, 1, 4'b1111, 1, 2'd2, 4'b0010, 32'h00A5_2211};
    vecs[6]  = '{0, 1, 2'd0, 8'h44, 1, 4'b1111, 1, 2'd3, 4'b0100, 32'h0033_2211};
    vecs[7]  = '{0, 1, 2'd0, 8'h00, 0, 4'b1111, 1, 2'd0, 4'b1000, 32'h4433_2211};
    vecs[8]  = '{0, 1, 2'd0, 8'h55, 1, 4'b0000, 1, 2'd0, 4'b0000, 32'h4433_2211};
    vecs[9]  = '{0, 0, 2'd1, 8'h66, 1, 4'b0000, 1, 2'd1, 4'b0001, 32'h4433_2255};
    vecs[10] = '{0, 1, 2'd0, 8'h77, 1, 4'b0000, 0, 2'd1, 4'b0011, 32'h4433_6655};
    vecs[11] = '{0, 1, 2'd0, 8'h77, 1, 4'b0000, 0, 2'd1, 4'b0011, 32'h4433_6655};
    vecs[12] = '{0, 1, 2'd0, 8'h77, 1, 4'b0000, 0, 2'd1, 4'b0011, 32'h4433_6655};
    vecs[13] = '{0, 1, 2'd0, 8'h77, 1, 4'b0010, 1, 2'd1, 4'b0011, 32'h4433_6655};
    vecs[14] = '{0, 1, 2'd0, 8'h00, 0, 4'b0000, 1, 2'd2, 4'b0011, 32'h4433_7755};
    vecs[15] = '{0, 0, 2'd0, 8'h01, 1, 4'b0001, 1, 2'd0, 4'b0011, 32'h4433_7755};
    vecs[16] = '{0, 0, 2'd0, 8'h02, 1, 4'b0001, 1, 2'd0, 4'b0011, 32'h4433_7701};
    vecs[17] = '{0, 0, 2'd0, 8'h00, 0, 4'b0000, 0, 2'd0, 4'b0011, 32'h4433_7702};
    vecs[18] = '{0, 0, 2'd3, 8'h99, 1, 4'b0010, 1, 2'd3, 4'b0011, 32'h4433_7702};
    vecs[19] = '{1, 1, 2'd0, 8'hAA, 1, 4'b0000, 1, 2'd2, 4'b1001, 32'h9933_7702};
    vecs[20] = '{0, 1, 2'd0, 8'h00, 0, 4'b0000, 1, 2'd0, 4'b0000, 32'h0000_0000};
    none     = vecs[0];

    apply(1, 0, 2'd0, 8'h00, 0, 4'b0000);
    step(0, none);
    step(0, none);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].auto_m, vecs[i].sel, vecs[i].data, vecs[i].valid,
            vecs[i].ordy);
      step(1, vecs[i]);
    end

    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0), 4'($urandom));
      step(0, none);
    end

`ifdef DEMUX_STATS_EN
    apply(1, 0, 2'd3, 8'h00, 0, 4'b0000);
    step(0, none);
    for (int i = 0; i < 300; i++) begin
      apply(0, 0, 2'd3, 8'(i), 1, 4'b1111);
      step(0, none);
    end
    apply(0, 0, 2'd3, 8'h00, 0, 4'b1111);
    step(0, none);
    chk("stats_saturated", 64'(acc_cnt), 64'h0000_0000_FF00_0000);
    apply(1, 0, 2'd0, 8'h00, 0, 4'b0000);
    step(0, none);
    chk("stats_cleared", 64'(acc_cnt), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
